// File: rtl/car_select_ctrl_if.sv
// rtl/car_select_ctrl_if.sv - car settings package and switch/IR-side bus interface
//
// car_select_pkg: CarSettings record, the four stock car presets and the
//   default settings table used when a design does not supply its own.
// car_select_ctrl_if: bundles the switch inputs, IR generator handshake and
//   selection outputs of car_select_ctrl.
//   switches_i      raw board switches (asynchronous)
//   tx_idle_i       IR packet generator is between packets
//   lock_i          blocks committing a new selection
//   selected_car_o  settings of the committed car
//   selected_idx_o  committed car index
//   changed_o       one-cycle pulse per commit
//   pending_o       a debounced selection is waiting for commit
//   leds_o          LEDs above the switches
//   slave modport = selector side, master modport = board/IR side.

package car_select_pkg;

  typedef struct packed {
    logic [3:0] car_id;
    logic [7:0] carrier_khz;
    logic [3:0] power;
  } CarSettings;

  localparam CarSettings BLUE_PARAMS   = '{car_id: 4'd1, carrier_khz: 8'd38, power: 4'd8};
  localparam CarSettings YELLOW_PARAMS = '{car_id: 4'd2, carrier_khz: 8'd40, power: 4'd9};
  localparam CarSettings GREEN_PARAMS  = '{car_id: 4'd3, carrier_khz: 8'd36, power: 4'd10};
  localparam CarSettings RED_PARAMS    = '{car_id: 4'd4, carrier_khz: 8'd56, power: 4'd12};

  // Stock table, entry 0 in the least significant slot. Designs take the low
  // CAR_COUNT entries; entries past the four colours repeat BLUE_PARAMS.
  localparam int DEFAULT_TABLE_CARS = 64;
  localparam logic [DEFAULT_TABLE_CARS*$bits(CarSettings)-1:0] DEFAULT_CAR_TABLE =
    {{(DEFAULT_TABLE_CARS-4){BLUE_PARAMS}}, RED_PARAMS, GREEN_PARAMS, YELLOW_PARAMS, BLUE_PARAMS};

endpackage

interface car_select_ctrl_if #(
  parameter int SEL_W = 2
) ();
  import car_select_pkg::*;

  logic [SEL_W-1:0] switches_i;
  logic             tx_idle_i;
  logic             lock_i;
  CarSettings       selected_car_o;
  logic [SEL_W-1:0] selected_idx_o;
  logic             changed_o;
  logic             pending_o;
  logic [SEL_W-1:0] leds_o;

  modport slave (
    input  switches_i, tx_idle_i, lock_i,
    output selected_car_o, selected_idx_o, changed_o, pending_o, leds_o
  );

  modport master (
    output switches_i, tx_idle_i, lock_i,
    input  selected_car_o, selected_idx_o, changed_o, pending_o, leds_o
  );

endinterface

// File: rtl/car_select_ctrl.sv
// rtl/car_select_ctrl.sv - registered, debounced car selector for the IR transmitter
//
// Synchronises and debounces the board switches, then commits a new car
// selection only while the IR packet generator is between packets and the
// selection is not locked, so a packet never carries mixed settings.
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  car_select_ctrl_if.slave (switches, tx_idle, lock in; selected
//        car/index, changed, pending, leds out)

module car_select_ctrl
  import car_select_pkg::*;
#(
  parameter int CAR_COUNT = 4,
  parameter CarSettings [CAR_COUNT-1:0] CAR_PARAMS =
    (CAR_COUNT*$bits(CarSettings))'(DEFAULT_CAR_TABLE),
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned BLINK_CYCLES = 25_000_000
) (
  input logic clk,
  input logic rst,
  car_select_ctrl_if.slave bus
);

  localparam int SEL_W = $clog2(CAR_COUNT);
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int BLK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [BLK_W-1:0] BLK_LAST  = BLK_W'(BLINK_CYCLES - 1);
  localparam logic [SEL_W:0]   CAR_LIMIT = (SEL_W+1)'(CAR_COUNT);

  typedef enum logic {IDLE, WAIT} state_t;

  logic [SEL_W-1:0] sync1_q, sync2_q;
  logic [SEL_W-1:0] cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] deb_q, deb_d;
  state_t           state_q, state_d;
  logic [SEL_W-1:0] sel_idx_q, sel_idx_d;
  CarSettings       sel_car_q, sel_car_d;
  logic             changed_q, changed_d;
  logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             phase_q, phase_d;
  logic             deb_valid;

  // Debounce: deb follows the candidate on the same edge the stability
  // counter reaches its last value, giving a 2 + DEBOUNCE_CYCLES latency.
  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    deb_d  = deb_q;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = '0;
    end else if (cnt_q != DEB_LAST) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (cnt_d == DEB_LAST) begin
      deb_d = cand_d;
    end
  end

  assign deb_valid = ({1'b0, deb_q} < CAR_LIMIT);

  always_comb begin
    state_d     = state_q;
    sel_idx_d   = sel_idx_q;
    sel_car_d   = sel_car_q;
    changed_d   = 1'b0;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    case (state_q)
      IDLE: begin
        if (deb_valid && (deb_q != sel_idx_q)) begin
          state_d     = WAIT;
          blink_cnt_d = '0;
          phase_d     = 1'b1;
        end
      end
      WAIT: begin
        // Target vanished (back to committed car or out of range): drop it.
        if (!deb_valid || (deb_q == sel_idx_q)) begin
          state_d = IDLE;
        end else if (bus.tx_idle_i && !bus.lock_i) begin
          state_d   = IDLE;
          sel_idx_d = deb_q;
          sel_car_d = CAR_PARAMS[deb_q];
          changed_d = 1'b1;
        end
        if (blink_cnt_q == BLK_LAST) begin
          blink_cnt_d = '0;
          phase_d     = ~phase_q;
        end else begin
          blink_cnt_d = blink_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      cand_q      <= '0;
      cnt_q       <= '0;
      deb_q       <= '0;
      state_q     <= IDLE;
      sel_idx_q   <= '0;
      sel_car_q   <= CAR_PARAMS[0];
      changed_q   <= 1'b0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      sync1_q     <= bus.switches_i;
      sync2_q     <= sync1_q;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      deb_q       <= deb_d;
      state_q     <= state_d;
      sel_idx_q   <= sel_idx_d;
      sel_car_q   <= sel_car_d;
      changed_q   <= changed_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  assign bus.selected_idx_o = sel_idx_q;
  assign bus.selected_car_o = sel_car_q;
  assign bus.changed_o      = changed_q;
  assign bus.pending_o      = (state_q == WAIT);
  assign bus.leds_o         = (state_q == WAIT) ? (phase_q ? deb_q : '0) : sel_idx_q;

endmodule

// File: doc/car_select_ctrl.md
# car_select_ctrl

Registered, debounced car selector for the IR transmitter. It replaces direct combinational switch decoding with a configurable number of cars and a per-car settings table. Switch inputs are synchronised and debounced. A new selection is committed only when the IR packet generator reports it is between packets and the selection is not locked, so a packet is never sent with mixed settings. The block sits between the board switches/LEDs and the IR packet generator.

## Interface

Parameters:
- CAR_COUNT, 4, number of selectable cars; must be at least 2.
- SEL_W, $clog2(CAR_COUNT), selector width; derived, not overridden.
- CAR_PARAMS, {BLUE_PARAMS, YELLOW_PARAMS, GREEN_PARAMS, RED_PARAMS, then BLUE_PARAMS for the remaining entries}, CarSettings array [CAR_COUNT] indexed by car number.
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles needed to accept a switch value (10 ms at 100 MHz); at least 1.
- BLINK_CYCLES, 25_000_000, half-period of the LED blink while a change is pending; at least 1.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  asynchronous, active-high reset.
- SWITCHES  in  SEL_W  raw board switches, asynchronous to CLK.
- TX_IDLE  in  1  high while the IR packet generator is between packets.
- LOCK  in  1  high blocks any commit of a new selection.
- SELECTED_CAR  out  CarSettings  registered CAR_PARAMS[SELECTED_IDX].
- SELECTED_IDX  out  SEL_W  committed car index.
- CHANGED  out  1  one-cycle pulse on each commit.
- PENDING  out  1  high while a debounced selection waits for commit.
- LEDS  out  SEL_W  LEDs above the switches.

## Operation

- Synchroniser: two-flop synchroniser per SWITCHES bit, producing sw_sync.
- Debounce:
  - A candidate register and a stability counter.
  - If sw_sync differs from the candidate: load the candidate and clear the counter.
  - Otherwise increment the counter, saturating at DEBOUNCE_CYCLES-1.
  - When the counter equals DEBOUNCE_CYCLES-1, copy the candidate into the debounced register (deb).
- Validity: deb is valid when deb < CAR_COUNT. An invalid deb is ignored: no pending state and no commit.
- FSM states IDLE and WAIT:
  - IDLE -> WAIT when deb is valid and deb != SELECTED_IDX.
  - WAIT -> IDLE, committing, when TX_IDLE=1 and LOCK=0. The commit target is deb at that edge, which must be valid and differ from SELECTED_IDX.
  - WAIT -> IDLE, not committing, when deb == SELECTED_IDX or deb is invalid.
  - If deb changes to another valid value while in WAIT, stay in WAIT; the newest deb is the target.
- Commit:
  - SELECTED_IDX <= deb.
  - SELECTED_CAR <= CAR_PARAMS[deb].
  - CHANGED high for exactly the following cycle.
- PENDING = (state == WAIT), registered.
- LEDS:
  - In IDLE: LEDS = SELECTED_IDX.
  - In WAIT: a blink counter is cleared on WAIT entry and a phase bit toggles every BLINK_CYCLES cycles, starting at 1. LEDS = deb when phase=1, else 0.

## Timing

- Reset values: sync flops, candidate, deb and counters 0; state IDLE; SELECTED_IDX 0; SELECTED_CAR CAR_PARAMS[0]; CHANGED 0; PENDING 0; LEDS 0.
- RESET asserted mid-WAIT abandons the pending change. There is no CHANGED pulse, and the outputs return to reset values immediately.
- Switch latency: a stable SWITCHES change updates deb 2 + DEBOUNCE_CYCLES cycles later. The FSM enters WAIT, and PENDING rises, one cycle after that.
- Commit latency: with TX_IDLE=1 and LOCK=0 sampled at the first WAIT cycle, SELECTED_IDX, SELECTED_CAR and CHANGED update on the next edge, and PENDING falls on that same edge.
- TX_IDLE and LOCK are sampled only in WAIT. TX_IDLE pulses shorter than one cycle are not seen.
- SELECTED_CAR and SELECTED_IDX change only on commit edges; they are glitch-free and consistent with each other in every cycle.
- A bounce shorter than DEBOUNCE_CYCLES never changes deb.

## Test plan

All scenarios use DEBOUNCE_CYCLES=4 and BLINK_CYCLES=3.

- Reset, then hold SWITCHES=0 for 20 cycles -> SELECTED_IDX=0, SELECTED_CAR=CAR_PARAMS[0], CHANGED never high, LEDS=0.
- SWITCHES 0->2 held, TX_IDLE=1, LOCK=0 -> deb=2 after 6 cycles, PENDING high 1 cycle later. On the next edge: SELECTED_IDX=2, SELECTED_CAR=GREEN_PARAMS, one-cycle CHANGED pulse, LEDS=2.
- SWITCHES toggles 0->1->0 with each value held 2 cycles -> deb stays 0, PENDING never rises.
- SWITCHES=3 with TX_IDLE=0 for 12 cycles -> PENDING high, LEDS alternates 3/0 every 3 cycles, no commit. Raise TX_IDLE -> commit to 3 (RED_PARAMS) on the next edge.
- SWITCHES=1 with LOCK=1 and TX_IDLE=1 -> stays in WAIT. Change SWITCHES back to the committed 0 -> WAIT->IDLE with no CHANGED pulse.
- CAR_COUNT=3, SWITCHES=3 -> ignored, PENDING low. Also: assert RESET during WAIT -> SELECTED_IDX=0, PENDING=0 immediately.
